// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache between MEM stage and a line-wide memory port.
// Optional DCACHE_STATS_EN adds hit_count/miss_count first-lookup counters.
module dcache_responder #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [31:0]             din,
  output logic                    is_ready,
  output logic                    is_output_valid,
  output logic [31:0]             dout,
  output logic                    is_hit,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [31:0]             mem_req_addr,
  output logic [32*LINE_WORDS-1:0] mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 30 - IW - OW;
  localparam int LW = 32 * LINE_WORDS;

  typedef enum logic [2:0] {
    IDLE, COMPARE, WRITEBACK, ALLOCATE, REFILL
  } state_t;

  state_t              state_q, state_d;
  logic [29:0]         waddr_q;
  logic [31:0]         wdata_q;
  logic                wr_q;
  logic                first_q;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TW-1:0]       tag_mem [NUM_SETS];
  logic [LW-1:0]       data_mem [NUM_SETS];

  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [LW-1:0] line;
  logic [LW-1:0] merged;
  logic [LW-1:0] wline;
  logic          hit, accept, data_we, tag_we;
  logic          unused_ok;

  assign unused_ok = ^addr[1:0];
  assign off    = waddr_q[OW-1:0];
  assign idx    = waddr_q[OW +: IW];
  assign tag    = waddr_q[29 -: TW];
  assign line   = data_mem[idx];
  assign hit    = valid_q[idx] && (tag_mem[idx] == tag);
  assign accept = (state_q == IDLE) && is_input_valid
                  && (mem_read || mem_write);

  always_comb begin
    merged = line;
    merged[{off, 5'b0} +: 32] = wdata_q;
  end

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    dout            = '0;
    is_hit          = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;
    mem_req_wdata   = '0;
    data_we         = 1'b0;
    tag_we          = 1'b0;
    wline           = mem_resp_rdata;
    unique case (state_q)
      IDLE: begin
        is_ready = 1'b1;
        if (accept) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          is_output_valid = !reset;
          is_hit          = first_q;
          if (wr_q) begin
            data_we      = 1'b1;
            wline        = merged;
            dirty_d[idx] = 1'b1;
          end else begin
            dout = line[{off, 5'b0} +: 32];
          end
          state_d = IDLE;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_mem[idx], idx, {(OW+2){1'b0}}};
        mem_req_wdata = line;
        if (mem_req_ready) begin
          dirty_d[idx] = 1'b0;
          state_d      = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag, idx, {(OW+2){1'b0}}};
        if (mem_req_ready) state_d = REFILL;
      end
      REFILL: ;
      default: state_d = IDLE;
    endcase
    // A refill may land in the same cycle its request is accepted
    if ((state_q == REFILL) ||
        (state_q == ALLOCATE && mem_req_ready)) begin
      if (mem_resp_valid) begin
        data_we      = 1'b1;
        tag_we       = 1'b1;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d      = COMPARE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      if (accept) first_q <= 1'b1;
      else if (state_q == COMPARE && !hit) first_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      waddr_q <= addr[31:2];
      wdata_q <= din;
      wr_q    <= mem_write;
    end
    if (data_we) data_mem[idx] <= wline;
    if (tag_we)  tag_mem[idx]  <= tag;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == COMPARE && first_q) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Randomized bench for dcache_responder: flat architectural memory model plus
// a per-set residency model predicts hits, writebacks and load data.
module tb_dcache_responder;
  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  dcache_responder dut (
    .clk(clk), .reset(reset),
    .is_input_valid(is_input_valid), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din),
    .is_ready(is_ready), .is_output_valid(is_output_valid),
    .dout(dout), .is_hit(is_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int m_hits = 0;
  int m_misses = 0;

  bit [31:0] back [bit [29:0]];
  bit [31:0] arch [bit [29:0]];
  bit [15:0] mv, md;
  bit [23:0] mt [16];

  function automatic bit [31:0] dflt(bit [29:0] w);
    return {w[13:0], w[15:0], 2'b01} ^ 32'h5A3C96E1;
  endfunction

  function automatic bit [31:0] back_rd(bit [29:0] w);
    return back.exists(w) ? back[w] : dflt(w);
  endfunction

  function automatic bit [31:0] arch_rd(bit [29:0] w);
    return arch.exists(w) ? arch[w] : back_rd(w);
  endfunction

  function automatic logic [127:0] line_of(bit [31:0] la, bit use_arch);
    logic [127:0] l;
    bit [29:0] w;
    for (int i = 0; i < 4; i++) begin
      w = la[31:2] + 30'(i);
      l[32*i +: 32] = use_arch ? arch_rd(w) : back_rd(w);
    end
    return l;
  endfunction

  task automatic model_clear();
    mv = '0;
    md = '0;
    arch.delete();
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic drive_junk(input bit en);
    is_input_valid = en;
    if (en) begin
      mem_read  = 1'($urandom_range(0, 1));
      mem_write = !mem_read;
      addr      = $urandom;
      din       = $urandom;
    end
  endtask

  task automatic do_op(input bit wr, input bit [31:0] a, input bit [31:0] d,
                       input int rw, input bit same, input int pw,
                       input bit junk);
    int s;
    bit [23:0] tg;
    bit hit;
    bit [31:0] la, ola;
    logic [127:0] exp_l;
    s   = int'(a[7:4]);
    tg  = a[31:8];
    la  = a & ~32'hF;
    hit = mv[s] && (mt[s] == tg);
    @(negedge clk);
    vecs++;
    if (is_ready !== 1'b1) begin
      errs++;
      $display("FAIL ready_idle: got %b want 1", is_ready);
    end
    is_input_valid = 1'b1;
    mem_read       = !wr;
    mem_write      = wr;
    addr           = a | 32'($urandom_range(0, 3));
    din            = d;
    mem_resp_valid = 1'($urandom_range(0, 1));
    mem_resp_rdata = {4{$urandom}};
    @(negedge clk);
    is_input_valid = 1'b0;
    mem_resp_valid = 1'b0;
    if (hit) m_hits++;
    else m_misses++;
    if (!hit) begin
      vecs++;
      if (is_output_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
        errs++;
        $display("FAIL compare_miss a=%h: ov=%b rv=%b want 0 0",
                 a, is_output_valid, mem_req_valid);
      end
      drive_junk(junk);
      @(negedge clk);
      if (md[s]) begin
        ola   = {mt[s], 4'(s), 4'h0};
        exp_l = line_of(ola, 1'b1);
        for (int k = 0; k <= rw; k++) begin
          vecs++;
          if ({mem_req_valid, mem_req_write, is_ready, is_output_valid}
                !== 4'b1100 || mem_req_addr !== ola
              || mem_req_wdata !== exp_l) begin
            errs++;
            $display("FAIL wb_req: got v%b w%b r%b a=%h d=%h want v1 w1 r0 a=%h d=%h",
                     mem_req_valid, mem_req_write, is_ready,
                     mem_req_addr, mem_req_wdata, ola, exp_l);
          end
          if (k == rw) mem_req_ready = 1'b1;
          drive_junk(junk);
          @(negedge clk);
          mem_req_ready = 1'b0;
        end
        for (int i = 0; i < 4; i++)
          back[ola[31:2] + 30'(i)] = exp_l[32*i +: 32];
        md[s] = 1'b0;
      end
      for (int k = 0; k <= rw; k++) begin
        vecs++;
        if ({mem_req_valid, mem_req_write, is_ready, is_output_valid}
              !== 4'b1000 || mem_req_addr !== la) begin
          errs++;
          $display("FAIL refill_req: got v%b w%b r%b a=%h want v1 w0 r0 a=%h",
                   mem_req_valid, mem_req_write, is_ready,
                   mem_req_addr, la);
        end
        if (k == rw) begin
          mem_req_ready = 1'b1;
          if (same) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = line_of(la, 1'b0);
          end
        end
        drive_junk(junk);
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
      end
      if (!same) begin
        for (int k = 0; k < pw; k++) begin
          vecs++;
          if (mem_req_valid !== 1'b0 || is_output_valid !== 1'b0
              || is_ready !== 1'b0) begin
            errs++;
            $display("FAIL refill_wait: rv=%b ov=%b r=%b want 0 0 0",
                     mem_req_valid, is_output_valid, is_ready);
          end
          drive_junk(junk);
          @(negedge clk);
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = line_of(la, 1'b0);
        drive_junk(junk);
        @(negedge clk);
        mem_resp_valid = 1'b0;
      end
      mv[s] = 1'b1;
      mt[s] = tg;
    end
    is_input_valid = 1'b0;
    vecs++;
    if (is_output_valid !== 1'b1 || is_hit !== hit
        || mem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL resp a=%h: ov=%b hit=%b rv=%b want 1 %b 0",
               a, is_output_valid, is_hit, mem_req_valid, hit);
    end
    if (!wr) begin
      vecs++;
      if (dout !== arch_rd(a[31:2])) begin
        errs++;
        $display("FAIL load_data a=%h: got %h want %h",
                 a, dout, arch_rd(a[31:2]));
      end
    end else begin
      arch[a[31:2]] = d;
      md[s] = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    vecs++;
    if ({is_ready, is_output_valid, is_hit, mem_req_valid, mem_req_write}
          !== 5'b10000 || dout !== 32'd0 || mem_req_addr !== 32'd0) begin
      errs++;
      $display("FAIL reset_state: r%b ov%b h%b rv%b w%b d=%h a=%h want r1 rest 0",
               is_ready, is_output_valid, is_hit, mem_req_valid,
               mem_req_write, dout, mem_req_addr);
    end
  endtask

  task automatic test_cold_load();
    back[30'h40] = 32'h11;
    back[30'h41] = 32'h22;
    back[30'h42] = 32'h33;
    back[30'h43] = 32'h44;
    do_op(1'b0, 32'h100, 32'h0, 0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_hit();
    do_op(1'b0, 32'h108, 32'h0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_dirty_evict();
    do_op(1'b1, 32'h104, 32'hDEADBEEF, 0, 1'b0, 0, 1'b0);
    do_op(1'b0, 32'h200, 32'h0, 1, 1'b0, 2, 1'b0);
    do_op(1'b0, 32'h104, 32'h0, 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_op(1'b0, 32'h1350, 32'h0, 5, 1'b0, 3, 1'b1);
    do_op(1'b1, 32'h2354, 32'h0BADF00D, 5, 1'b0, 2, 1'b1);
    do_op(1'b0, 32'h1358, 32'h0, 5, 1'b1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_refill();
    do_op(1'b0, 32'h0A00, 32'h0, 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_read       = 1'b1;
    mem_write      = 1'b0;
    addr           = 32'h100;
    @(negedge clk);
    is_input_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
      errs++;
      $display("FAIL mid_refill_req: rv=%b a=%h want 1 00000100",
               mem_req_valid, mem_req_addr);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready  = 1'b0;
    reset          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = line_of(32'h100, 1'b0);
    @(negedge clk);
    reset          = 1'b0;
    mem_resp_valid = 1'b0;
    model_clear();
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (mem_req_valid !== 1'b0 || is_output_valid !== 1'b0
          || is_ready !== 1'b1) begin
        errs++;
        $display("FAIL abort: rv=%b ov=%b r=%b want 0 0 1",
                 mem_req_valid, is_output_valid, is_ready);
      end
      @(negedge clk);
    end
    do_op(1'b0, 32'h100, 32'h0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    bit [31:0] a;
    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 3)) << 12)
        | (32'($urandom_range(0, 15)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      do_op(1'($urandom_range(0, 1)), a, $urandom,
            $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    do_op(1'b0, 32'h40, 32'h0, 0, 1'b0, 0, 1'b0);
    do_op(1'b0, 32'h40, 32'h0, 0, 1'b0, 0, 1'b0);
    do_op(1'b1, 32'h44, 32'h1234, 0, 1'b0, 0, 1'b0);
    do_op(1'b0, 32'h48, 32'h0, 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    vecs++;
    if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_misses)) begin
      errs++;
      $display("FAIL stats: hits=%0d misses=%0d want %0d %0d",
               hit_count, miss_count, m_hits, m_misses);
    end
  endtask
`endif

  initial begin
    reset          = 1'b1;
    is_input_valid = 1'b0;
    addr           = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    din            = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    test_reset();
    test_cold_load();
    test_hit();
    test_dirty_evict();
    test_backpressure();
    test_reset_mid_refill();
    test_random();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the pipeline's MEM stage (request initiator) and backing data memory.
- Accepts one word load/store per handshake and responds with data plus a hit flag.
- On a miss, it runs a multi-cycle line writeback/refill against a line-wide memory port. The pipeline stalls while is_ready is low.

Parameters:
- NUM_SETS, 16, number of cache lines (power of 2; index width = log2(NUM_SETS)).
- LINE_WORDS, 4, 32-bit words per line (power of 2; line width = 32*LINE_WORDS bits).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- is_input_valid  input  1  CPU request present
- addr  input  32  byte address; bits [1:0] ignored
- mem_read  input  1  load request
- mem_write  input  1  store request (mem_read and mem_write never both 1)
- din  input  32  store data
- is_ready  output  1  cache can accept a request this cycle
- is_output_valid  output  1  one-cycle pulse: response valid
- dout  output  32  load data, valid with is_output_valid
- is_hit  output  1  request hit on first lookup, valid with is_output_valid
- mem_req_valid  output  1  backing-memory request
- mem_req_ready  input  1  backing memory accepts request
- mem_req_write  output  1  1 = line write (writeback), 0 = line read (refill)
- mem_req_addr  output  32  line-aligned byte address
- mem_req_wdata  output  32*LINE_WORDS  writeback line
- mem_resp_valid  input  1  refill data valid (single-cycle pulse)
- mem_resp_rdata  input  32*LINE_WORDS  refill line

Behaviour:
- Address split:
  - word offset = addr[log2(LINE_WORDS)+1:2]
  - index = next log2(NUM_SETS) bits
  - tag = remaining upper bits
- Storage per line: valid bit, dirty bit, tag, and data line.
- Reset:
  - state = IDLE.
  - All valid/dirty bits clear; data/tag contents don't-care.
  - is_ready=1 after reset deasserts; is_output_valid=0, dout=0, is_hit=0.
  - mem_req_valid=0, mem_req_write=0, mem_req_addr=0.
- is_ready = 1 only in IDLE.
- Request accepted when is_input_valid && is_ready && (mem_read || mem_write). Address, din and op are latched on acceptance. Inputs in non-IDLE states are ignored.
- IDLE -> COMPARE on acceptance.
- COMPARE:
  - Hit (valid && tag match):
    - Load: dout = word.
    - Store: write word, set dirty.
    - Pulse is_output_valid with is_hit=1 if this is the first lookup, 0 if after a refill.
    - -> IDLE.
    - Hit latency: accepted in cycle N, response in cycle N+1.
  - Miss and line dirty -> WRITEBACK.
  - Miss and line clean or invalid -> ALLOCATE.
- WRITEBACK:
  - mem_req_valid=1, mem_req_write=1, addr = {old tag, index, 0}, wdata = line.
  - Fields held stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready: clear dirty, -> ALLOCATE. No response is expected for writes.
- ALLOCATE:
  - mem_req_valid=1, mem_req_write=0, addr = {new tag, index, 0}, held until mem_req_ready.
  - After acceptance, mem_req_valid=0 and the block waits for mem_resp_valid.
  - On mem_resp_valid: install line, valid=1, dirty=0, tag=new, -> COMPARE. The lookup now hits and is reported with is_hit=0.
  - mem_resp_valid in the same cycle as mem_req_ready is legal and is treated as refill complete.
- At most one outstanding memory request. mem_resp_valid outside the ALLOCATE wait is ignored.
- Reset mid-operation (any state) aborts: mem_req_valid=0 on the next cycle, no response pulse, and all lines are invalidated.
- Store-miss: refill first, then merge the store word and set dirty.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count (32) and miss_count (32).
  - Each increments by 1 in the cycle a COMPARE from first lookup resolves, as hit or miss respectively.
  - Both cleared on reset; both wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold load: load addr 0x100, memory returns line words {0x11,0x22,0x33,0x44} -> refill request with mem_req_write=0, mem_req_addr=0x100; response dout=0x11, is_hit=0.
- Hit: next, load 0x108 -> is_output_valid exactly 1 cycle after acceptance, dout=0x33, is_hit=1, no mem_req_valid.
- Store hit then dirty eviction:
  - Store 0xDEADBEEF to 0x104 -> is_hit=1.
  - Load 0x200 (same index, NUM_SETS=16) -> writeback request with addr 0x100 and wdata word1=0xDEADBEEF.
  - Then refill from 0x200.
  - Response has is_hit=0.
- Backpressure: hold mem_req_ready=0 for 5 cycles during ALLOCATE -> mem_req_valid/addr stable throughout, is_ready=0 throughout, requests presented meanwhile are ignored.
- Reset mid-refill: assert reset while waiting on mem_resp_valid -> no is_output_valid pulse, mem_req_valid=0 next cycle; subsequent load 0x100 misses again.
- DCACHE_STATS_EN: run 1 miss, 3 hits -> miss_count=1, hit_count=3.
